osnt_sume_10g_rx_queue: RTL and testbench
=========================================

Name: osnt_sume_10g_rx_queue

Overview:
Receive-side queue between the 10G MAC RX stream and the OSNT monitor datapath. It store-and-forwards whole frames and latches the arrival timestamp on the first beat. It extracts the transmit timestamp embedded at a configurable word position by the TX queue, computes one-way latency, and emits each packet with a 128-bit tuser metadata word. Packets that cannot be fully buffered are dropped whole and counted.

Parameters:
C_M_AXIS_DATA_WIDTH, 64, output data width (only 64 supported)
C_S_AXIS_DATA_WIDTH, 64, input data width (only 64 supported)
C_M_AXIS_TUSER_WIDTH, 128, output metadata width
C_S_AXI_DATA_WIDTH, 32, register width for rx_ts_pos and counters
TS_WIDTH, 64, timestamp width
SRC_PORT, 8'h01, one-hot source port code placed in tuser[23:16]
MAX_PKT_WORDS, 500, admission threshold in 64-bit words (4000 B)
DATA_DEPTH_BITS, 10, log2 depth of the data FIFO (1024 words)
META_DEPTH_BITS, 5, log2 depth of the metadata FIFO

Ports:
axis_aclk  in  1  clock, 156.25 MHz domain
axis_resetn  in  1  reset, asynchronous, active-low
s_axis_tdata  in  64  MAC RX data
s_axis_tkeep  in  8  byte enables, contiguous from bit 0
s_axis_tuser  in  1  bad-frame flag, meaningful on the tlast beat
s_axis_tvalid  in  1  beat valid; no backpressure, so there is no s_axis_tready
s_axis_tlast  in  1  last beat
m_axis_tdata  out  64  packet data
m_axis_tkeep  out  8  byte enables
m_axis_tuser  out  128  metadata, valid on every beat of the packet
m_axis_tvalid  out  1  output valid
m_axis_tready  in  1  downstream ready
m_axis_tlast  out  1  last beat
rx_ts_pos  in  32  beat index (0-based) of the embedded TX timestamp; 0 = disabled
timestamp_156  in  64  free-running timestamp
clear  in  1  synchronous clear of all counters
rx_pkt_count  out  32  packets forwarded
rx_drop_count  out  32  packets dropped at admission
rx_err_count  out  32  packets forwarded with the bad-frame flag

Behaviour:
- Clock/reset: one clock, axis_aclk. Reset axis_resetn is asynchronous and active-low. In reset: all outputs 0, both FSMs in IDLE, FIFOs empty, counters 0.
- Write FSM states:
  - W_IDLE: on s_axis_tvalid, admit if data-FIFO free words >= MAX_PKT_WORDS and the meta FIFO is not nearly full. Admitted: write the beat, latch timestamp_156 as rx_ts, word_cnt=1, go W_PKT. Not admitted: go W_DROP.
  - Single-beat packet (tvalid & tlast in W_IDLE): admitted packets push meta immediately and stay in W_IDLE; refused packets increment rx_drop_count and stay in W_IDLE.
  - W_PKT: write each valid beat, word_cnt+1, byte_len += popcount(tkeep). When rx_ts_pos!=0 and word_cnt==rx_ts_pos, capture tdata as tx_ts and set ts_ok.
  - W_PKT on tlast: push meta {err=tuser, ts_ok, len, rx_ts, tx_ts}, then W_IDLE.
  - W_DROP: discard beats; on tlast increment rx_drop_count, then W_IDLE.
- Metadata: latency = (rx_ts - tx_ts)[31:0], modulo arithmetic. If ts_ok=0, latency=0 and tx_ts=0.
- tuser layout: [15:0] byte length; [23:16] SRC_PORT; [24] bad frame; [25] ts_ok; [31:26] 0; [63:32] latency; [127:64] rx_ts.
- Read FSM states:
  - IDLE: go HEAD when the meta FIFO is not empty. Always spends ≥1 cycle in IDLE between packets.
  - HEAD/SEND: tvalid = data FIFO not empty. Pop on tvalid&tready. On the popped tlast beat: pop meta, go IDLE, increment rx_pkt_count, and increment rx_err_count if err.
- Output holds stable while tvalid & ~tready.
- Latency: first output beat is presented no earlier than 2 cycles after the input tlast beat.
- clear has priority over increments in the same cycle. Counters wrap at 2^32.
- Reset asserted mid-packet: the partial packet is lost and nothing is emitted.
- A packet ending before beat rx_ts_pos is forwarded with ts_ok=0.

Optional Feature:
RX_TS_OVERWRITE_EN. When defined, the beat at index rx_ts_pos (rx_ts_pos!=0) is stored with tdata replaced by rx_ts, so downstream sees the arrival time in-band. When undefined, data passes unmodified. Metadata extraction is identical in both builds.

Test Plan:
- Single packet: 8 beats, tkeep final 8'h0F, rx_ts_pos=0 -> 8 identical beats out, tuser[15:0]=60, tuser[25]=0, rx_pkt_count=1.
- Timestamp extraction: rx_ts_pos=2, beat 2 = 64'h100, timestamp_156=64'h180 at first beat -> tuser[63:32]=32'h80, tuser[25]=1. With RX_TS_OVERWRITE_EN, output beat 2 = 64'h180.
- Short packet: 2 beats with rx_ts_pos=5 -> ts_ok=0, latency 0.
- Bad frame: s_axis_tuser=1 on tlast -> packet forwarded, tuser[24]=1, rx_err_count=1.
- Overflow: hold m_axis_tready=0 and send 3 packets of 400 beats -> third dropped whole, rx_drop_count=1. Release ready -> exactly 2 packets out, intact and in order.
- Backpressure and clear: toggle m_axis_tready randomly -> data identical to input, one IDLE gap per packet. Pulse clear coincident with a tlast pop -> counters read 0.

Source files
------------

// File: rtl/osnt_sume_10g_rx_queue.sv
// osnt_sume_10g_rx_queue
// Store-and-forward receive queue between the 10G MAC RX stream and the OSNT
// monitor path. A frame is admitted on its first beat only if a worst-case
// frame fits in the data FIFO. Otherwise the whole frame is dropped and counted.
// The arrival time is latched on the first beat. A transmit timestamp is pulled
// from beat rx_ts_pos, and every output beat carries a 128-bit tuser word.
// Optional build macro RX_TS_OVERWRITE_EN replaces the data of beat rx_ts_pos
// with the arrival timestamp. Metadata is the same in both builds.
module osnt_sume_10g_rx_queue #(
  parameter int         C_M_AXIS_DATA_WIDTH  = 64,
  parameter int         C_S_AXIS_DATA_WIDTH  = 64,
  parameter int         C_M_AXIS_TUSER_WIDTH = 128,
  parameter int         C_S_AXI_DATA_WIDTH   = 32,
  parameter int         TS_WIDTH             = 64,
  parameter logic [7:0] SRC_PORT             = 8'h01,
  parameter int         MAX_PKT_WORDS        = 500,
  parameter int         DATA_DEPTH_BITS      = 10,
  parameter int         META_DEPTH_BITS      = 5
) (
  input  logic                              axis_aclk,
  input  logic                              axis_resetn,
  input  logic [C_S_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  s_axis_tkeep,
  input  logic                              s_axis_tuser,
  input  logic                              s_axis_tvalid,
  input  logic                              s_axis_tlast,
  output logic [C_M_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
  output logic [C_M_AXIS_DATA_WIDTH/8-1:0]  m_axis_tkeep,
  output logic [C_M_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
  output logic                              m_axis_tvalid,
  input  logic                              m_axis_tready,
  output logic                              m_axis_tlast,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]     rx_ts_pos,
  input  logic [TS_WIDTH-1:0]               timestamp_156,
  input  logic                              clear,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     rx_pkt_count,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     rx_drop_count,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     rx_err_count
);
  localparam int DATA_DEPTH = 1 << DATA_DEPTH_BITS;
  localparam int META_DEPTH = 1 << META_DEPTH_BITS;
  localparam int DCW        = DATA_DEPTH_BITS + 1;
  localparam int MCW        = META_DEPTH_BITS + 1;
  localparam int KW         = C_S_AXIS_DATA_WIDTH / 8;

  typedef enum logic [1:0] {W_IDLE, W_PKT, W_DROP} wstate_t;
  typedef enum logic [1:0] {R_IDLE, R_HEAD, R_SEND} rstate_t;

  function automatic logic [15:0] keep_bytes(input logic [KW-1:0] k);
    logic [15:0] n;
    n = '0;
    for (int i = 0; i < KW; i++) n = n + {15'd0, k[i]};
    return n;
  endfunction

  // Data FIFO storage: one entry per beat
  logic [C_S_AXIS_DATA_WIDTH-1:0] data_mem [DATA_DEPTH];
  logic [KW-1:0]                  keep_mem [DATA_DEPTH];
  logic                           last_mem [DATA_DEPTH];
  logic [DATA_DEPTH_BITS-1:0]     d_wr_ptr, d_rd_ptr;
  logic [DCW-1:0]                 d_count;

  // Metadata FIFO storage: one entry per forwarded frame
  logic                 m_err_mem  [META_DEPTH];
  logic                 m_tsok_mem [META_DEPTH];
  logic [15:0]          m_len_mem  [META_DEPTH];
  logic [TS_WIDTH-1:0]  m_rxts_mem [META_DEPTH];
  logic [TS_WIDTH-1:0]  m_txts_mem [META_DEPTH];
  logic [META_DEPTH_BITS-1:0] m_wr_ptr, m_rd_ptr;
  logic [MCW-1:0]             m_count;

  wstate_t                       w_state;
  rstate_t                       r_state;
  logic [C_S_AXI_DATA_WIDTH-1:0] word_cnt;
  logic [15:0]                   byte_len;
  logic [TS_WIDTH-1:0]           rx_ts, tx_ts;
  logic                          ts_ok;

  logic                           admit, d_full, ts_hit, d_push, m_push, drop_inc;
  logic [C_S_AXIS_DATA_WIDTH-1:0] d_wdata;
  logic [15:0]                    beat_len, m_len_in;
  logic [TS_WIDTH-1:0]            m_rxts_in, m_txts_in;
  logic                           m_tsok_in;
  logic                           d_pop, pop_last;
  logic [31:0]                    latency;

  assign admit    = (32'(d_count) + 32'(MAX_PKT_WORDS) <= 32'(DATA_DEPTH)) &&
                    (32'(m_count) < 32'(META_DEPTH - 1));
  assign d_full   = (32'(d_count) == 32'(DATA_DEPTH));
  assign beat_len = keep_bytes(s_axis_tkeep);
  assign ts_hit   = (w_state == W_PKT) && (rx_ts_pos != '0) && (word_cnt == rx_ts_pos);

  // Write-side decode: FIFO pushes, stored data and metadata for this beat
  always_comb begin
    d_push    = 1'b0;
    m_push    = 1'b0;
    drop_inc  = 1'b0;
    d_wdata   = s_axis_tdata;
    m_len_in  = byte_len + beat_len;
    m_rxts_in = rx_ts;
    m_tsok_in = ts_ok | ts_hit;
    m_txts_in = ts_hit ? s_axis_tdata : tx_ts;
`ifdef RX_TS_OVERWRITE_EN
    if (ts_hit) d_wdata = rx_ts;
`endif
    case (w_state)
      W_IDLE: begin
        m_len_in  = beat_len;
        m_rxts_in = timestamp_156;
        m_tsok_in = 1'b0;
        m_txts_in = '0;
        if (s_axis_tvalid) begin
          if (admit) begin
            d_push = 1'b1;
            m_push = s_axis_tlast;
          end else begin
            drop_inc = s_axis_tlast;
          end
        end
      end
      W_PKT: begin
        if (s_axis_tvalid) begin
          d_push = ~d_full;
          m_push = s_axis_tlast;
        end
      end
      default: drop_inc = s_axis_tvalid & s_axis_tlast;
    endcase
  end

  // Write FSM: admission, beat counting and timestamp capture
  always_ff @(posedge axis_aclk or negedge axis_resetn) begin
    if (!axis_resetn) begin
      w_state  <= W_IDLE;
      word_cnt <= '0;
      byte_len <= '0;
      rx_ts    <= '0;
      tx_ts    <= '0;
      ts_ok    <= 1'b0;
    end else begin
      case (w_state)
        W_IDLE: if (s_axis_tvalid) begin
          if (admit) begin
            word_cnt <= C_S_AXI_DATA_WIDTH'(1);
            byte_len <= beat_len;
            rx_ts    <= timestamp_156;
            tx_ts    <= '0;
            ts_ok    <= 1'b0;
            if (!s_axis_tlast) w_state <= W_PKT;
          end else if (!s_axis_tlast) begin
            w_state <= W_DROP;
          end
        end
        W_PKT: if (s_axis_tvalid) begin
          word_cnt <= word_cnt + 1'b1;
          byte_len <= byte_len + beat_len;
          if (ts_hit) begin
            tx_ts <= s_axis_tdata;
            ts_ok <= 1'b1;
          end
          if (s_axis_tlast) w_state <= W_IDLE;
        end
        default: if (s_axis_tvalid && s_axis_tlast) w_state <= W_IDLE;
      endcase
    end
  end

  // FIFO storage writes (data path, no reset)
  always_ff @(posedge axis_aclk) begin
    if (d_push) begin
      data_mem[d_wr_ptr] <= d_wdata;
      keep_mem[d_wr_ptr] <= s_axis_tkeep;
      last_mem[d_wr_ptr] <= s_axis_tlast;
    end
    if (m_push) begin
      m_err_mem[m_wr_ptr]  <= s_axis_tuser;
      m_tsok_mem[m_wr_ptr] <= m_tsok_in;
      m_len_mem[m_wr_ptr]  <= m_len_in;
      m_rxts_mem[m_wr_ptr] <= m_rxts_in;
      m_txts_mem[m_wr_ptr] <= m_tsok_in ? m_txts_in : '0;
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge axis_aclk or negedge axis_resetn) begin
    if (!axis_resetn) begin
      d_wr_ptr <= '0;
      d_rd_ptr <= '0;
      d_count  <= '0;
      m_wr_ptr <= '0;
      m_rd_ptr <= '0;
      m_count  <= '0;
    end else begin
      if (d_push) d_wr_ptr <= d_wr_ptr + 1'b1;
      if (d_pop)  d_rd_ptr <= d_rd_ptr + 1'b1;
      d_count <= d_count + DCW'(d_push) - DCW'(d_pop);
      if (m_push)   m_wr_ptr <= m_wr_ptr + 1'b1;
      if (pop_last) m_rd_ptr <= m_rd_ptr + 1'b1;
      m_count <= m_count + MCW'(m_push) - MCW'(pop_last);
    end
  end

  assign m_axis_tvalid = (r_state != R_IDLE) && (d_count != '0);
  assign d_pop         = m_axis_tvalid & m_axis_tready;
  assign pop_last      = d_pop & last_mem[d_rd_ptr];
  assign latency       = m_tsok_mem[m_rd_ptr] ?
                         (m_rxts_mem[m_rd_ptr][31:0] - m_txts_mem[m_rd_ptr][31:0]) : 32'd0;
  assign m_axis_tdata  = m_axis_tvalid ? data_mem[d_rd_ptr] : '0;
  assign m_axis_tkeep  = m_axis_tvalid ? keep_mem[d_rd_ptr] : '0;
  assign m_axis_tlast  = m_axis_tvalid & last_mem[d_rd_ptr];
  assign m_axis_tuser  = m_axis_tvalid ?
                         {m_rxts_mem[m_rd_ptr], latency, 6'd0, m_tsok_mem[m_rd_ptr],
                          m_err_mem[m_rd_ptr], SRC_PORT, m_len_mem[m_rd_ptr]} : '0;

  // Read FSM: wait for a complete frame, stream it, then idle one cycle
  always_ff @(posedge axis_aclk or negedge axis_resetn) begin
    if (!axis_resetn) begin
      r_state <= R_IDLE;
    end else begin
      case (r_state)
        R_IDLE:  if (m_count != '0) r_state <= R_HEAD;
        R_HEAD:  if (d_pop) r_state <= pop_last ? R_IDLE : R_SEND;
        default: if (pop_last) r_state <= R_IDLE;
      endcase
    end
  end

  // Statistics counters; clear wins over a same-cycle increment
  always_ff @(posedge axis_aclk or negedge axis_resetn) begin
    if (!axis_resetn) begin
      rx_pkt_count  <= '0;
      rx_drop_count <= '0;
      rx_err_count  <= '0;
    end else if (clear) begin
      rx_pkt_count  <= '0;
      rx_drop_count <= '0;
      rx_err_count  <= '0;
    end else begin
      if (pop_last) rx_pkt_count <= rx_pkt_count + 1'b1;
      if (pop_last && m_err_mem[m_rd_ptr]) rx_err_count <= rx_err_count + 1'b1;
      if (drop_inc) rx_drop_count <= rx_drop_count + 1'b1;
    end
  end
endmodule

// File: tb/tb_osnt_sume_10g_rx_queue.sv
// Testbench for osnt_sume_10g_rx_queue: directed table, overflow, clear,
// mid-packet reset and randomized traffic against a frame-level model.
`timescale 1ns/1ps
module tb_osnt_sume_10g_rx_queue;
  logic         axis_aclk;
  logic         axis_resetn;
  logic [63:0]  s_axis_tdata;
  logic [7:0]   s_axis_tkeep;
  logic         s_axis_tuser, s_axis_tvalid, s_axis_tlast;
  logic [63:0]  m_axis_tdata;
  logic [7:0]   m_axis_tkeep;
  logic [127:0] m_axis_tuser;
  logic         m_axis_tvalid, m_axis_tready, m_axis_tlast;
  logic [31:0]  rx_ts_pos;
  logic [63:0]  timestamp_156;
  logic         clear;
  logic [31:0]  rx_pkt_count, rx_drop_count, rx_err_count;

  osnt_sume_10g_rx_queue dut (
    .axis_aclk(axis_aclk), .axis_resetn(axis_resetn),
    .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep), .s_axis_tuser(s_axis_tuser),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tlast(s_axis_tlast),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tuser(m_axis_tuser),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
    .rx_ts_pos(rx_ts_pos), .timestamp_156(timestamp_156), .clear(clear),
    .rx_pkt_count(rx_pkt_count), .rx_drop_count(rx_drop_count), .rx_err_count(rx_err_count)
  );

  initial begin
    axis_aclk = 1'b0;
    forever #5 axis_aclk = ~axis_aclk;
  end

  typedef struct {
    logic [63:0]  data;
    logic [7:0]   keep;
    logic         last;
    logic [127:0] tuser;
  } beat_t;

  typedef struct {
    int          n;
    logic [63:0] base;
    logic [7:0]  lastkeep;
    logic        err;
    int          pos;
    logic [63:0] ts0;
    logic [15:0] e_len;
    logic        e_tsok;
    logic        e_err;
    logic [31:0] e_lat;
    int          e_pkts;
  } vec_t;

  int errors = 0;
  int checks = 0;
  beat_t exp_q[$];
  int in_words = 0, out_words = 0, in_pkts = 0, pkts_seen = 0;
  int exp_errs = 0, exp_drops = 0;
  int pkt_base = 0, err_base = 0, drop_base = 0;
  logic [127:0] last_tuser = '0;
  int rdy_mode = 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Output ready driver: 0 = held low, 1 = held high, 2 = random, 3 = manual
  initial begin
    m_axis_tready = 1'b0;
    forever begin
      @(posedge axis_aclk);
      #1;
      case (rdy_mode)
        0: m_axis_tready = 1'b0;
        1: m_axis_tready = 1'b1;
        2: m_axis_tready = 1'($urandom_range(0, 1));
        default: ;
      endcase
    end
  end

  // Output monitor / scoreboard, sampled on the falling edge
  logic  prev_stall = 1'b0, prev_lastpop = 1'b0;
  beat_t prev_b;
  always @(negedge axis_aclk) begin
    beat_t b;
    if (axis_resetn) begin
      if (prev_lastpop) check("idle_gap", m_axis_tvalid, 0);
      if (prev_stall) begin
        check("hold_data", m_axis_tdata, prev_b.data);
        check("hold_tuser", m_axis_tuser, prev_b.tuser);
        check("hold_ctrl", {m_axis_tvalid, m_axis_tkeep, m_axis_tlast}, {1'b1, prev_b.keep, prev_b.last});
      end
      if (m_axis_tvalid && m_axis_tready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat: got %0h expected none", m_axis_tdata);
        end else begin
          b = exp_q.pop_front();
          check("beat_data", m_axis_tdata, b.data);
          check("beat_keep", m_axis_tkeep, b.keep);
          check("beat_last", m_axis_tlast, b.last);
          check("beat_tuser", m_axis_tuser, b.tuser);
        end
        out_words++;
        if (m_axis_tlast) begin
          pkts_seen++;
          last_tuser = m_axis_tuser;
        end
      end
      prev_stall   = m_axis_tvalid && !m_axis_tready;
      prev_lastpop = m_axis_tvalid && m_axis_tready && m_axis_tlast;
      prev_b.data  = m_axis_tdata;
      prev_b.keep  = m_axis_tkeep;
      prev_b.last  = m_axis_tlast;
      prev_b.tuser = m_axis_tuser;
    end else begin
      prev_stall   = 1'b0;
      prev_lastpop = 1'b0;
    end
  end

  // Frame-level model: decide admission, build expected beats, then drive the frame
  task automatic send_pkt(input int n, input logic [63:0] base, input logic [7:0] lastkeep,
                          input logic err, input logic [63:0] ts0, input bit rnd);
    logic [63:0]  d[$];
    logic [63:0]  tx;
    logic [31:0]  lat;
    logic [127:0] tu;
    bit           admit, tsok;
    int           len, pos;
    beat_t        b;
    pos = int'(rx_ts_pos);
    for (int i = 0; i < n; i++) d.push_back(rnd ? {$urandom, $urandom} : base + 64'(i));
    admit = (1024 - (in_words - out_words) >= 500) && (in_pkts - pkts_seen < 31);
    len   = 8 * (n - 1) + $countones(lastkeep);
    tsok  = (pos != 0) && (pos < n);
    tx    = tsok ? d[pos] : 64'd0;
    lat   = tsok ? (ts0[31:0] - tx[31:0]) : 32'd0;
    tu    = {ts0, lat, 6'd0, tsok, err, 8'h01, 16'(len)};
    if (admit) begin
      for (int i = 0; i < n; i++) begin
        b.data  = d[i];
`ifdef RX_TS_OVERWRITE_EN
        if (pos != 0 && i == pos) b.data = ts0;
`endif
        b.keep  = (i == n - 1) ? lastkeep : 8'hFF;
        b.last  = (i == n - 1);
        b.tuser = tu;
        exp_q.push_back(b);
      end
      in_words += n;
      in_pkts++;
      if (err) exp_errs++;
    end else begin
      exp_drops++;
    end
    for (int i = 0; i < n; i++) begin
      @(posedge axis_aclk);
      #1;
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = d[i];
      s_axis_tkeep  = (i == n - 1) ? lastkeep : 8'hFF;
      s_axis_tlast  = (i == n - 1);
      s_axis_tuser  = (i == n - 1) ? err : 1'b0;
      timestamp_156 = ts0 + 64'(i);
    end
    @(posedge axis_aclk);
    #1;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    s_axis_tuser  = 1'b0;
  endtask

  task automatic wait_pkts(input int target, input int budget, input string name);
    int c = 0;
    while (pkts_seen < target && c < budget) begin
      @(posedge axis_aclk);
      c++;
    end
    #1;
    checks++;
    if (pkts_seen < target) begin
      errors++;
      $display("FAIL %s: got %0d packets required %0d", name, pkts_seen, target);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        tbl[6];
    logic [63:0] ts_cur;
    int          seen0, c;
    logic [7:0]  lk;
    axis_resetn = 1'b0;
    s_axis_tvalid = 1'b0; s_axis_tdata = '0; s_axis_tkeep = '0;
    s_axis_tlast = 1'b0; s_axis_tuser = 1'b0;
    rx_ts_pos = '0; timestamp_156 = '0; clear = 1'b0;

    //          n  base          lk     err pos ts0           len    tsok err lat            pkts
    tbl[0] = '{8, 64'h1000,     8'h0F, 0,  0,  64'h500,      16'd60, 0,   0,  32'h0,        1};
    tbl[1] = '{4, 64'hFE,       8'hFF, 0,  2,  64'h180,      16'd32, 1,   0,  32'h80,       2};
    tbl[2] = '{2, 64'h2000,     8'hFF, 0,  5,  64'h900,      16'd16, 0,   0,  32'h0,        3};
    tbl[3] = '{3, 64'h3000,     8'h01, 1,  0,  64'hA00,      16'd17, 0,   1,  32'h0,        4};
    tbl[4] = '{1, 64'h4000,     8'h03, 0,  0,  64'hB00,      16'd2,  0,   0,  32'h0,        5};
    tbl[5] = '{3, 64'h10,       8'hFF, 0,  2,  64'h5,        16'd24, 1,   0,  32'hFFFFFFF3, 6};

    repeat (3) @(posedge axis_aclk);
    #1;
    check("rst_tvalid", m_axis_tvalid, 0);
    check("rst_tdata", m_axis_tdata, 0);
    check("rst_tuser", m_axis_tuser, 0);
    check("rst_counts", {rx_pkt_count, rx_drop_count, rx_err_count}, 0);
    axis_resetn = 1'b1;
    repeat (2) @(posedge axis_aclk);
    #1;

    // Directed table
    rdy_mode = 1;
    for (int i = 0; i < 6; i++) begin
      rx_ts_pos = 32'(tbl[i].pos);
      send_pkt(tbl[i].n, tbl[i].base, tbl[i].lastkeep, tbl[i].err, tbl[i].ts0, 0);
      wait_pkts(i + 1, 200, "tbl_wait");
      check("tbl_len", last_tuser[15:0], tbl[i].e_len);
      check("tbl_src", last_tuser[23:16], 8'h01);
      check("tbl_err", last_tuser[24], tbl[i].e_err);
      check("tbl_tsok", last_tuser[25], tbl[i].e_tsok);
      check("tbl_lat", last_tuser[63:32], tbl[i].e_lat);
      check("tbl_rxts", last_tuser[127:64], tbl[i].ts0);
      check("tbl_pkt_count", rx_pkt_count, tbl[i].e_pkts);
    end
    check("tbl_err_count", rx_err_count, 1);
    check("tbl_drop_count", rx_drop_count, 0);

    // Clear coincident with the popped tlast of an errored frame
    rdy_mode = 3;
    @(posedge axis_aclk);
    #1;
    m_axis_tready = 1'b0;
    rx_ts_pos = '0;
    send_pkt(1, 64'h5000, 8'hFF, 1'b1, 64'hC00, 0);
    c = 0;
    while (!m_axis_tvalid && c < 50) begin
      @(posedge axis_aclk);
      #1;
      c++;
    end
    check("clr_tvalid", m_axis_tvalid, 1);
    check("clr_pre_pkt", rx_pkt_count, 6);
    m_axis_tready = 1'b1;
    clear = 1'b1;
    @(posedge axis_aclk);
    #1;
    clear = 1'b0;
    m_axis_tready = 1'b0;
    check("clr_pkt", rx_pkt_count, 0);
    check("clr_err", rx_err_count, 0);
    check("clr_drop", rx_drop_count, 0);
    pkt_base = in_pkts; err_base = exp_errs; drop_base = exp_drops;

    // Overflow: three 400-beat frames with output stalled
    rdy_mode = 0;
    ts_cur = 64'h10000;
    seen0 = pkts_seen;
    for (int i = 0; i < 3; i++) begin
      send_pkt(400, 0, 8'hFF, 1'b0, ts_cur, 1);
      ts_cur += 64'd500;
    end
    repeat (5) @(posedge axis_aclk);
    #1;
    check("ovf_drop_count", rx_drop_count, 1);
    check("ovf_drop_model", rx_drop_count, exp_drops - drop_base);
    check("ovf_no_output", pkts_seen, seen0);
    rdy_mode = 1;
    wait_pkts(seen0 + 2, 2000, "ovf_wait");
    repeat (20) @(posedge axis_aclk);
    #1;
    check("ovf_pkts", pkts_seen, seen0 + 2);
    check("ovf_pkt_count", rx_pkt_count, 2);
    check("ovf_queue_empty", exp_q.size(), 0);

    // Randomized traffic with random backpressure
    rdy_mode = 2;
    ts_cur = {$urandom, $urandom};
    for (int p = 0; p < 40; p++) begin
      c = 0;
      while (((in_words - out_words) > 300 || (in_pkts - pkts_seen) > 20) && c < 3000) begin
        @(posedge axis_aclk);
        c++;
      end
      #1;
      rx_ts_pos = 32'($urandom_range(0, 6));
      lk = 8'hFF >> $urandom_range(0, 7);
      send_pkt($urandom_range(1, 30), 0, lk, 1'($urandom_range(0, 1)), ts_cur, 1);
      ts_cur += 64'($urandom_range(40, 200));
      repeat ($urandom_range(0, 2)) @(posedge axis_aclk);
      #1;
    end
    c = 0;
    while (exp_q.size() != 0 && c < 5000) begin
      @(posedge axis_aclk);
      c++;
    end
    repeat (3) @(posedge axis_aclk);
    #1;
    check("rnd_drain", exp_q.size(), 0);
    check("rnd_pkt_count", rx_pkt_count, in_pkts - pkt_base);
    check("rnd_err_count", rx_err_count, exp_errs - err_base);
    check("rnd_drop_count", rx_drop_count, exp_drops - drop_base);

    // Reset in the middle of an incoming frame
    rdy_mode = 1;
    for (int i = 0; i < 5; i++) begin
      @(posedge axis_aclk);
      #1;
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = 64'hDEAD_0000 + 64'(i);
      s_axis_tkeep  = 8'hFF;
      s_axis_tlast  = 1'b0;
    end
    #2;
    axis_resetn = 1'b0;
    #1;
    check("mid_rst_tvalid", m_axis_tvalid, 0);
    check("mid_rst_counts", {rx_pkt_count, rx_drop_count, rx_err_count}, 0);
    s_axis_tvalid = 1'b0;
    @(posedge axis_aclk);
    #1;
    axis_resetn = 1'b1;
    in_words = out_words;
    seen0 = pkts_seen;
    repeat (20) @(posedge axis_aclk);
    #1;
    check("mid_rst_no_output", pkts_seen, seen0);
    check("mid_rst_idle", m_axis_tvalid, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
